dm_tx_reader: RTL and testbench

//  Read-side streamer for a PE data memory: fetches a block of words from the

---
 rtl/dm_tx_reader_pkg.sv | 14 +
 rtl/dm_tx_reader_tx_fifo.sv | 49 ++++
 rtl/dm_tx_reader.sv | 108 ++++++++++
 tb/tb_dm_tx_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_tx_reader_pkg.sv
// Shared constants and FSM encoding for the data-memory transfer reader.
package dm_tx_reader_pkg;
    localparam int DM_DATA_W     = 32;
    localparam int DM_ADDR_W     = 8;
    localparam int DM_RD_LAT     = 2;
    localparam int DM_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/dm_tx_reader_tx_fifo.sv
// Small synchronous FIFO; head entry is read straight from registered storage.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/dm_tx_reader.sv
// Streams a block of data-memory words to the neighbour PE, prefetching through
// a credit-limited FIFO so the BRAM read latency is hidden.
module dm_tx_reader
    import dm_tx_reader_pkg::*;
#(
    parameter int DATA_W     = DM_DATA_W,
    parameter int ADDR_W     = DM_ADDR_W,
    parameter int RD_LAT     = DM_RD_LAT,
    parameter int FIFO_DEPTH = DM_FIFO_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_last_o,
    input  logic              tx_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, last_addr_q, rd_addr;
    logic [ADDR_W:0]   len_q, issued_q, sent_q;
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       outstanding, credit;
    logic              rd_en, pop, push, fifo_valid;
    logic [DATA_W-1:0] fifo_head;

    // Credit = words in flight + words buffered, net of this cycle's pop.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < RD_LAT; i++)
            outstanding = outstanding + (CW+1)'(vld_pipe_q[i]);
        pop    = fifo_valid & tx_ready_i;
        credit = outstanding + (CW+1)'(fifo_count) - (CW+1)'(pop);
        rd_en  = (state_q == ST_READ) && (issued_q != len_q) &&
                 (credit < (CW+1)'(FIFO_DEPTH));
        rd_addr = rd_en ? (base_q + issued_q[ADDR_W-1:0]) : last_addr_q;
        vld_pipe_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    assign push = vld_pipe_q[RD_LAT-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_READ;
            ST_READ:  if (rd_en && (issued_q + (ADDR_W+1)'(1) == len_q)) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && (sent_q + (ADDR_W+1)'(1) == len_q)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            last_addr_q <= '0;
            vld_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            vld_pipe_q <= vld_pipe_d;
            if (state_q == ST_IDLE && start_i) begin
                base_q   <= base_addr_i;
                len_q    <= len_i;
                issued_q <= '0;
                sent_q   <= '0;
            end
            if (rd_en) begin
                issued_q    <= issued_q + (ADDR_W+1)'(1);
                last_addr_q <= rd_addr;
            end
            if (pop) sent_q <= sent_q + (ADDR_W+1)'(1);
        end
    end

    tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W), .CW(CW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (rd_data_i),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign busy_o     = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign rd_en_o    = rd_en;
    assign rd_addr_o  = rd_addr;
    assign tx_valid_o = fifo_valid;
    assign tx_data_o  = fifo_head;
    assign tx_last_o  = fifo_valid && (sent_q == len_q - (ADDR_W+1)'(1));
endmodule

// File: tb/tb_dm_tx_reader.sv
// Scoreboard bench: driver queues expected reads/words, a negedge monitor checks them.
module tb_dm_tx_reader;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, rd_en, tx_valid, tx_last, tx_ready;
    logic [7:0]  base_addr, rd_addr;
    logic [8:0]  len;
    logic [31:0] rd_data, tx_data, s1;
    logic [31:0] mem [256];

    int tests = 0, fails = 0, cyc = 0;
    int n_rd, n_acc, first_vld, first_rd, last_rd, done_cyc, done_cnt, t_start;
    int ready_mode = 0, rcnt = 0;
    logic [32:0] exp_q [$];
    logic [7:0]  addr_q [$];
    logic        stall_q = 1'b0;
    logic [31:0] stall_data;

    dm_tx_reader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .len_i(len), .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
        .rd_addr_o(rd_addr), .rd_data_i(rd_data), .tx_valid_o(tx_valid),
        .tx_data_o(tx_data), .tx_last_o(tx_last), .tx_ready_i(tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-stage registered BRAM read
    always @(posedge clk) begin
        if (rd_en) s1 <= mem[rd_addr];
        rd_data <= s1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (addr_q.size() == 0) fail_now("rd_unexpected");
                else chk("rd_addr", rd_addr, addr_q.pop_front());
                chk("credit", ((n_rd - n_acc - int'(tx_valid && tx_ready)) <= 4), 1);
            end
            if (tx_valid && first_vld < 0) first_vld = cyc;
            if (stall_q) chk("stall_hold", {tx_valid, tx_data}, {1'b1, stall_data});
            if (tx_valid && tx_ready) begin
                n_acc++;
                if (exp_q.size() == 0) fail_now("tx_unexpected");
                else chk("tx_word", {tx_last, tx_data}, exp_q.pop_front());
            end
            stall_q    = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // tx_ready driver
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       tx_ready = (rcnt < 8) ? (rcnt % 2 == 0) : (rcnt >= 18);
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b1;
            endcase
            rcnt++;
        end
    end

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] l, input bit track);
        logic [7:0] a;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        len = l;
        if (track) begin
            n_rd = 0; n_acc = 0; first_vld = -1; first_rd = -1; last_rd = -1;
            done_cnt = 0; done_cyc = -1; rcnt = 0;
            for (int k = 0; k < int'(l); k++) begin
                a = b + 8'(k);
                addr_q.push_back(a);
                exp_q.push_back({(k == int'(l) - 1), mem[a]});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) t_start = cyc;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == 0) fail_now({name, "_done_timeout"});
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_exp_left"}, exp_q.size(), 0);
        chk({name, "_addr_left"}, addr_q.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(name, {busy, done, rd_en, tx_valid, tx_last, rd_addr, tx_data}, 64'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++)
            mem[i] = {8'hC3, 8'(i), ~8'(i), 8'(i) ^ 8'h5A};
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        n_rd = 0; n_acc = 0; first_vld = -1; first_rd = -1; last_rd = -1;
        done_cnt = 0; done_cyc = -1; t_start = 0;
        #12;
        chk_idle_outputs("reset_outputs");
        @(posedge clk); #1; rst = 1'b0;

        // 1: basic block, back-to-back
        start_xfer(8'h10, 9'd8, 1'b1);
        wait_done(200, "t1");
        chk("t1_first_valid", first_vld, t_start + 3);
        chk("t1_rd_span", last_rd - first_rd, 7);
        chk("t1_first_rd", first_rd, t_start);
        chk("t1_done_cycle", done_cyc, t_start + 11);
        chk("t1_accepted", n_acc, 8);

        // 2: address wrap
        start_xfer(8'hFE, 9'd4, 1'b1);
        wait_done(200, "t2");
        chk("t2_accepted", n_acc, 4);

        // 3: back-pressure
        ready_mode = 1;
        start_xfer(8'h33, 9'd16, 1'b1);
        wait_done(400, "t3");
        chk("t3_accepted", n_acc, 16);
        ready_mode = 0;

        // 4: zero length, then start while busy
        start_xfer(8'h55, 9'd0, 1'b1);
        wait_done(50, "t4a");
        chk("t4a_done_cycle", done_cyc, t_start);
        chk("t4a_no_reads", n_rd, 0);
        chk("t4a_no_valid", first_vld, -1);
        start_xfer(8'h20, 9'd8, 1'b1);
        repeat (2) @(posedge clk);
        #1; start = 1'b1; base_addr = 8'h90; len = 9'd3;
        @(posedge clk);
        #1; start = 1'b0;
        wait_done(200, "t4b");
        chk("t4b_reads", n_rd, 8);
        chk("t4b_accepted", n_acc, 8);
        chk("t4b_done_cycle", done_cyc, t_start + 11);
        chk("t4b_idle_after", busy, 0);

        // 5: reset mid-transfer
        start_xfer(8'h30, 9'd16, 1'b1);
        k = 0;
        while (n_acc < 5 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (n_acc < 5) fail_now("t5_progress_timeout");
        #2; rst = 1'b1;
        #1;
        chk_idle_outputs("t5_reset_outputs");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        start_xfer(8'h40, 9'd2, 1'b1);
        wait_done(100, "t5");
        chk("t5_accepted", n_acc, 2);

        // 6: full sweep with random back-pressure
        ready_mode = 2;
        start_xfer(8'h80, 9'd256, 1'b1);
        wait_done(3000, "t6");
        chk("t6_accepted", n_acc, 256);
        chk("t6_reads", n_rd, 256);
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
